alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_seq.sv | 54 +++++
 rtl/alu_mc.sv | 150 +++++++++++++++
 tb/tb_alu_mc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the multi-cycle ALU.
package alu_pkg;

  localparam int CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_RXOR = 4'h5,
    OP_NOT  = 4'h6,
    OP_MUL  = 4'h7,
    OP_SHL  = 4'hE,
    OP_SHR  = 4'hF
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH bits in total.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_count;
  logic               r_busy;

  // Bit 0 of the multiplier is consumed on the start edge, so done is
  // visible WIDTH-1 cycles later and the owner can latch on the WIDTH-th.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
      r_mcand  <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
      r_mplier <= i_b >> 1;
      r_count  <= CNT_W'(WIDTH - 1);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_count != '0) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count - CNT_W'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done    = r_busy && (r_count == '0);
  assign o_product = r_acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops are decoded
// here, MUL is delegated to the sequential shift-add unit.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] alu_cmd,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic             carry,
  output logic             zero,
  output logic             beq,
  output logic             slt,
  output logic             err
);

  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_rslt;
  logic               r_carry;
  logic               r_zero;
  logic               r_beq;
  logic               r_slt;
  logic               r_err;

  alu_op_t            w_op;
  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_err;

  assign w_op        = alu_op_t'(alu_cmd);
  assign w_accept    = in_valid && r_in_ready;
  assign w_mul_start = w_accept && (w_op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_mul_start),
    .i_a      (inA),
    .i_b      (inB),
    .o_done   (w_mul_done),
    .o_product(w_product)
  );

  // Single-cycle result; the extra top bit of sum/diff is carry/borrow.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_err   = 1'b0;
    w_sum   = {1'b0, inA} + {1'b0, inB};
    w_diff  = {1'b0, inA} - {1'b0, inB};
    case (w_op)
      OP_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
      OP_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
      OP_AND:  w_res = inA & inB;
      OP_OR:   w_res = inA | inB;
      OP_XOR:  w_res = inA ^ inB;
      OP_RXOR: w_res = {{(WIDTH-1){1'b0}}, ^inA};
      OP_NOT:  w_res = ~inA;
      OP_MUL:  w_res = '0;
      OP_SHL:  w_res = (inB >= SHIFT_LIM) ? '0 : (inA << inB);
      OP_SHR:  w_res = (inB >= SHIFT_LIM) ? '0 : (inA >> inB);
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_rslt      <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_beq       <= 1'b0;
      r_slt       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_beq      <= (inA == inB);
            r_slt      <= (inA < inB);
            if (w_op == OP_MUL) begin
              r_state <= ST_MUL;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_rslt      <= w_res;
              r_carry     <= w_carry;
              r_zero      <= (w_res == '0);
              r_err       <= w_err;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_rslt      <= w_product[WIDTH-1:0];
            r_carry     <= |w_product[2*WIDTH-1:WIDTH];
            r_zero      <= (w_product[WIDTH-1:0] == '0);
            r_err       <= 1'b0;
          end
        end
        ST_DONE: begin
          // Return to IDLE only; the next accept happens a cycle later.
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign rslt      = r_rslt;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign beq       = r_beq;
  assign slt       = r_slt;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus randomized
// traffic compared against an arithmetic reference model.
module tb_alu_mc;

  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int MASK = MOD - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_cmd;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] rslt;
  logic         carry, zero, beq, slt, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_cmd  (alu_cmd),
    .inA      (inA),
    .inB      (inB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rslt     (rslt),
    .carry    (carry),
    .zero     (zero),
    .beq      (beq),
    .slt      (slt),
    .err      (err)
  );

  // Reference: flags are {carry, zero, beq, slt, err}
  task automatic model(input logic [3:0] cmd, input int a, input int b,
                       output logic [W-1:0] expRes, output logic [4:0] expFlags);
    int     r;
    longint p;
    logic   c, e;
    r = 0; c = 1'b0; e = 1'b0;
    case (cmd)
      4'h0: begin r = (a + b) % MOD; c = (a + b) >= MOD; end
      4'h1: begin r = (a - b + MOD) % MOD; c = a < b; end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = $countones(a) % 2;
      4'h6: r = (~a) & MASK;
      4'h7: begin p = longint'(a) * longint'(b); r = int'(p % MOD); c = (p / MOD) != 0; end
      4'hE: r = (b >= W) ? 0 : ((a << b) % MOD);
      4'hF: r = (b >= W) ? 0 : (a >> b);
      default: e = 1'b1;
    endcase
    expRes   = W'(r);
    expFlags = {c, r == 0, a == b, a < b, e};
  endtask

  task automatic applyStimulus(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; alu_cmd = cmd; inA = a; inB = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_cmd  = 4'($urandom);
    inA      = W'($urandom);
    inB      = W'($urandom);
  endtask

  task automatic waitOutValid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; alu_cmd = 4'h0; inA = 8'h11; inB = 8'h22; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, rslt, carry, zero, beq, slt, err} !== {1'b1, 1'b0, 8'h00, 5'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b rslt=%h flags=%b required rdy=1 vld=0 rslt=00 flags=00000",
               in_ready, out_valid, rslt, {carry, zero, beq, slt, err});
    end
    reset = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_no_accept: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [3:0]   dCmd [6] = '{4'h0, 4'h7, 4'h7, 4'hE, 4'hF, 4'hA};
    logic [W-1:0] dA   [6] = '{8'hF0, 8'd13, 8'h20, 8'h01, 8'h80, 8'h33};
    logic [W-1:0] dB   [6] = '{8'h20, 8'd11, 8'h10, 8'd9,  8'd7,  8'h33};
    logic [W-1:0] expRes;
    logic [4:0]   expFlags;
    int           lat, expLat;
    for (int i = 0; i < 6; i++) begin
      model(dCmd[i], int'(dA[i]), int'(dB[i]), expRes, expFlags);
      expLat = (dCmd[i] == 4'h7) ? W + 1 : 1;
      applyStimulus(dCmd[i], dA[i], dB[i]);
      waitOutValid(lat);
      checks++;
      if (lat != expLat || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL dir_latency[%0d]: got %0d cycles (vld=%b) required %0d", i, lat, out_valid, expLat);
      end
      checks++;
      if (rslt !== expRes) begin
        errors++;
        $display("[TB] FAIL dir_rslt[%0d] cmd=%h: got %h required %h", i, dCmd[i], rslt, expRes);
      end
      checks++;
      if ({carry, zero, beq, slt, err} !== expFlags) begin
        errors++;
        $display("[TB] FAIL dir_flags[%0d] cmd=%h: got %b required %b", i, dCmd[i], {carry, zero, beq, slt, err}, expFlags);
      end
      releaseResult();
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] expRes;
    logic [4:0]   expFlags;
    int           lat;
    model(4'h1, 5, 7, expRes, expFlags);
    applyStimulus(4'h1, 8'h05, 8'h07);
    waitOutValid(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; alu_cmd = 4'h0; inA = W'($urandom); inB = W'($urandom);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || rslt !== expRes || {carry, zero, beq, slt, err} !== expFlags) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got vld=%b rdy=%b rslt=%h flags=%b required vld=1 rdy=0 rslt=%h flags=%b",
                 i, out_valid, in_ready, rslt, {carry, zero, beq, slt, err}, expRes, expFlags);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    releaseResult();
  endtask

  task automatic test_mul_reset();
    logic [W-1:0] expRes;
    logic [4:0]   expFlags;
    int           lat, seen;
    applyStimulus(4'h7, 8'd200, 8'd3);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, rslt, carry, zero, beq, slt, err} !== {1'b1, 1'b0, 8'h00, 5'b0}) begin
      errors++;
      $display("[TB] FAIL mulreset_state: got rdy=%b vld=%b rslt=%h flags=%b required rdy=1 vld=0 rslt=00 flags=00000",
               in_ready, out_valid, rslt, {carry, zero, beq, slt, err});
    end
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL mulreset_discard: got %0d valid cycles required 0", seen);
    end
    model(4'h0, 1, 1, expRes, expFlags);
    applyStimulus(4'h0, 8'h01, 8'h01);
    waitOutValid(lat);
    checks++;
    if (lat != 1 || rslt !== expRes || {carry, zero, beq, slt, err} !== expFlags) begin
      errors++;
      $display("[TB] FAIL mulreset_add: got lat=%0d rslt=%h flags=%b required lat=1 rslt=%h flags=%b",
               lat, rslt, {carry, zero, beq, slt, err}, expRes, expFlags);
    end
    releaseResult();
  endtask

  task automatic test_back_to_back();
    logic [3:0]   cmd, nCmd;
    logic [W-1:0] a, b;
    logic [W-1:0] expRes, nRes;
    logic [4:0]   expFlags, nFlags;
    int           lat;
    cmd = 4'h7; a = 8'hFF; b = 8'hFF;
    model(cmd, int'(a), int'(b), expRes, expFlags);
    applyStimulus(cmd, a, b);
    for (int k = 0; k < 6; k++) begin
      waitOutValid(lat);
      checks++;
      if (out_valid !== 1'b1 || rslt !== expRes || {carry, zero, beq, slt, err} !== expFlags) begin
        errors++;
        $display("[TB] FAIL b2b_result[%0d] cmd=%h: got vld=%b rslt=%h flags=%b required vld=1 rslt=%h flags=%b",
                 k, cmd, out_valid, rslt, {carry, zero, beq, slt, err}, expRes, expFlags);
      end
      nCmd = 4'($urandom_range(0, 7));
      a = W'($urandom); b = W'($urandom);
      model(nCmd, int'(a), int'(b), nRes, nFlags);
      in_valid = 1'b1; alu_cmd = nCmd; inA = a; inB = b; out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_no_same_cycle_accept[%0d]: got vld=%b rdy=%b required vld=0 rdy=1", k, out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cmd = nCmd; expRes = nRes; expFlags = nFlags;
    end
    waitOutValid(lat);
    checks++;
    if (rslt !== expRes || {carry, zero, beq, slt, err} !== expFlags) begin
      errors++;
      $display("[TB] FAIL b2b_last: got rslt=%h flags=%b required rslt=%h flags=%b",
               rslt, {carry, zero, beq, slt, err}, expRes, expFlags);
    end
    releaseResult();
  endtask

  task automatic test_random();
    logic [3:0]   cmd;
    logic [W-1:0] a, b;
    logic [W-1:0] expRes;
    logic [4:0]   expFlags;
    int           lat, expLat;
    for (int i = 0; i < 40; i++) begin
      cmd = 4'($urandom_range(0, 15));
      a   = W'($urandom);
      b   = (cmd >= 4'hE) ? W'($urandom_range(0, 12)) : W'($urandom);
      if (i % 7 == 0) b = a;
      model(cmd, int'(a), int'(b), expRes, expFlags);
      expLat = (cmd == 4'h7) ? W + 1 : 1;
      applyStimulus(cmd, a, b);
      waitOutValid(lat);
      checks++;
      if (lat != expLat || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rnd_latency[%0d] cmd=%h: got %0d required %0d", i, cmd, lat, expLat);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (rslt !== expRes || {carry, zero, beq, slt, err} !== expFlags) begin
        errors++;
        $display("[TB] FAIL rnd_result[%0d] cmd=%h a=%h b=%h: got rslt=%h flags=%b required rslt=%h flags=%b",
                 i, cmd, a, b, rslt, {carry, zero, beq, slt, err}, expRes, expFlags);
      end
      releaseResult();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_mul_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
